// File: rtl/xadac_pkg.sv
// Shared types and constants for the xadac accelerator ports and the int8 vector dot-product unit.
package xadac_pkg;
  localparam int IdWidth      = 4;
  localparam int InstrWidth   = 32;
  localparam int RegAddrWidth = 5;
  localparam int RegDataWidth = 32;
  localparam int VecDataWidth = 128;
  localparam int VecElemWidth = 8;
  localparam int VecLen       = VecDataWidth / VecElemWidth;
  localparam int ProdWidth    = 17;
  localparam int NumRs        = 2;
  localparam int NumVs        = 3;

  localparam logic [6:0] OpcCustom0 = 7'b0001011;
  localparam logic [2:0] F3VdotS    = 3'b000;
  localparam logic [2:0] F3VdotU    = 3'b001;

  typedef logic signed [ProdWidth-1:0] VecProdT;

  typedef struct packed {
    logic [IdWidth-1:0]    id;
    logic [InstrWidth-1:0] instr;
  } DecReqT;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic               accept;
    logic               rd_clobber;
    logic               vd_clobber;
    logic [NumRs-1:0]   rs_read;
    logic [NumVs-1:0]   vs_read;
  } DecRspT;

  typedef struct packed {
    logic [IdWidth-1:0]                        id;
    logic [InstrWidth-1:0]                     instr;
    logic [NumRs-1:0][RegAddrWidth-1:0]        rs_addr;
    logic [NumRs-1:0][RegDataWidth-1:0]        rs_data;
    logic [NumVs-1:0][RegAddrWidth-1:0]        vs_addr;
    logic [NumVs-1:0][VecDataWidth-1:0]        vs_data;
  } ExeReqT;

  typedef struct packed {
    logic [IdWidth-1:0]      id;
    logic [RegAddrWidth-1:0] rd_addr;
    logic [RegDataWidth-1:0] rd_data;
    logic                    rd_write;
    logic [RegAddrWidth-1:0] vd_addr;
    logic [VecDataWidth-1:0] vd_data;
    logic                    vd_write;
  } ExeRspT;

  function automatic logic is_vdot(input logic [6:0] opcode, input logic [2:0] funct3,
                                   input logic [6:0] claimed);
    return (opcode == claimed) && ((funct3 == F3VdotS) || (funct3 == F3VdotU));
  endfunction
endpackage

// File: rtl/xadac_vdot_if.sv
// Decode and execute request/response channels between the core issue port and the unit.
interface xadac_vdot_if;
  import xadac_pkg::*;

  DecReqT dec_req;
  logic   dec_req_valid;
  logic   dec_req_ready;
  DecRspT dec_rsp;
  logic   dec_rsp_valid;
  logic   dec_rsp_ready;

  ExeReqT exe_req;
  logic   exe_req_valid;
  logic   exe_req_ready;
  ExeRspT exe_rsp;
  logic   exe_rsp_valid;
  logic   exe_rsp_ready;

  modport master (
    output dec_req, dec_req_valid, dec_rsp_ready,
    input  dec_req_ready, dec_rsp, dec_rsp_valid,
    output exe_req, exe_req_valid, exe_rsp_ready,
    input  exe_req_ready, exe_rsp, exe_rsp_valid
  );

  modport slave (
    input  dec_req, dec_req_valid, dec_rsp_ready,
    output dec_req_ready, dec_rsp, dec_rsp_valid,
    input  exe_req, exe_req_valid, exe_rsp_ready,
    output exe_req_ready, exe_rsp, exe_rsp_valid
  );
endinterface

// File: rtl/xadac_dot_tree.sv
// Combinational reduction: addend plus the sign-extended sum of VecLen 17-bit products, mod 2^32.
module xadac_dot_tree
  import xadac_pkg::*;
(
  input  logic [VecLen-1:0][ProdWidth-1:0] i_prods,
  input  logic [RegDataWidth-1:0]          i_addend,
  output logic [RegDataWidth-1:0]          o_sum
);
  VecProdT                 w_p;
  logic [RegDataWidth-1:0] w_acc;

  always_comb begin
    w_acc = i_addend;
    w_p   = '0;
    for (int i = 0; i < VecLen; i++) begin
      w_p   = VecProdT'(i_prods[i]);
      w_acc = w_acc + RegDataWidth'(w_p);
    end
  end

  assign o_sum = w_acc;
endmodule

// File: rtl/xadac_vdot.sv
// xadac responder for VDOT.S/VDOT.U: registered decode verdicts and a 2-stage
// backpressured int8 dot-product pipeline (S1 products, S2 reduction/output).
module xadac_vdot
  import xadac_pkg::*;
#(
  parameter logic [6:0] Opcode = OpcCustom0
) (
  input logic         clk_i,
  input logic         rst_ni,
  xadac_vdot_if.slave bus
);
  localparam int Stages = 2;

  logic   w_dec_ld, w_dec_acc, r_dec_vld;
  DecRspT w_dec_rsp, r_dec_rsp;

  assign w_dec_acc = is_vdot(bus.dec_req.instr[6:0], bus.dec_req.instr[14:12], Opcode);
  assign w_dec_ld  = !r_dec_vld || bus.dec_rsp_ready;

  always_comb begin
    w_dec_rsp            = '0;
    w_dec_rsp.id         = bus.dec_req.id;
    w_dec_rsp.accept     = w_dec_acc;
    w_dec_rsp.rd_clobber = w_dec_acc;
    w_dec_rsp.rs_read    = w_dec_acc ? 2'b01 : 2'b00;
    w_dec_rsp.vs_read    = w_dec_acc ? 3'b011 : 3'b000;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dec_vld <= 1'b0;
      r_dec_rsp <= '0;
    end else if (w_dec_ld) begin
      r_dec_vld <= bus.dec_req_valid;
      if (bus.dec_req_valid) r_dec_rsp <= w_dec_rsp;
    end
  end

  assign bus.dec_req_ready = w_dec_ld;
  assign bus.dec_rsp_valid = r_dec_vld;
  assign bus.dec_rsp       = r_dec_rsp;

  logic [Stages:1]                  r_vld_pipe;
  logic                             w_s1_ld, w_s2_ld, w_exe_ok, w_exe_sgn;
  logic [VecLen-1:0][ProdWidth-1:0] w_prod, r_prod;
  logic [RegDataWidth-1:0]          r_rs0, w_sum;
  logic [IdWidth-1:0]               r_id;
  logic [RegAddrWidth-1:0]          r_rd;
  logic                             r_wr;
  ExeRspT                           w_rsp, r_rsp;

  // A stage advances when its successor can take its contents this cycle.
  assign w_s2_ld   = !r_vld_pipe[2] || bus.exe_rsp_ready;
  assign w_s1_ld   = !r_vld_pipe[1] || w_s2_ld;
  assign w_exe_ok  = is_vdot(bus.exe_req.instr[6:0], bus.exe_req.instr[14:12], Opcode);
  assign w_exe_sgn = (bus.exe_req.instr[14:12] == F3VdotS);

  for (genvar g = 0; g < VecLen; g++) begin : g_lane
    logic [VecElemWidth-1:0]     w_ea, w_eb;
    logic signed [ProdWidth-1:0] w_xa, w_xb;
    assign w_ea      = bus.exe_req.vs_data[0][g*VecElemWidth +: VecElemWidth];
    assign w_eb      = bus.exe_req.vs_data[1][g*VecElemWidth +: VecElemWidth];
    assign w_xa      = {{(ProdWidth-VecElemWidth){w_exe_sgn & w_ea[VecElemWidth-1]}}, w_ea};
    assign w_xb      = {{(ProdWidth-VecElemWidth){w_exe_sgn & w_eb[VecElemWidth-1]}}, w_eb};
    assign w_prod[g] = w_xa * w_xb;
  end

  xadac_dot_tree u_tree (
    .i_prods  (r_prod),
    .i_addend (r_rs0),
    .o_sum    (w_sum)
  );

  always_comb begin
    w_rsp          = '0;
    w_rsp.id       = r_id;
    w_rsp.rd_addr  = r_rd;
    w_rsp.rd_data  = r_wr ? w_sum : '0;
    w_rsp.rd_write = r_wr;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_vld_pipe <= '0;
      r_prod     <= '0;
      r_rs0      <= '0;
      r_id       <= '0;
      r_rd       <= '0;
      r_wr       <= 1'b0;
      r_rsp      <= '0;
    end else begin
      if (w_s1_ld) begin
        r_vld_pipe[1] <= bus.exe_req_valid;
        if (bus.exe_req_valid) begin
          r_prod <= w_prod;
          r_rs0  <= bus.exe_req.rs_data[0];
          r_id   <= bus.exe_req.id;
          r_rd   <= bus.exe_req.instr[11:7];
          r_wr   <= w_exe_ok;
        end
      end
      if (w_s2_ld) begin
        r_vld_pipe[2] <= r_vld_pipe[1];
        if (r_vld_pipe[1]) r_rsp <= w_rsp;
      end
    end
  end

  assign bus.exe_req_ready = w_s1_ld;
  assign bus.exe_rsp_valid = r_vld_pipe[2];
  assign bus.exe_rsp       = r_rsp;

  // Operand fields this unit never consumes.
  logic w_unused;
  assign w_unused = ^{bus.dec_req.instr[31:15], bus.dec_req.instr[11:7],
                      bus.exe_req.instr[31:15], bus.exe_req.rs_addr,
                      bus.exe_req.rs_data[1], bus.exe_req.vs_addr, bus.exe_req.vs_data[2]};
endmodule
